// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage load/store engine with sub-word read-modify-write on a word-wide memory port
module load_store_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemReq,
  input  logic        MemWrite,
  input  logic [1:0]  MemSize,
  input  logic        MemSigned,
  input  logic [31:0] MemAddr,
  input  logic [31:0] MemWData,
  output logic [31:0] MemRData,
  output logic        MemDone,
  output logic        MemStall,
  output logic        MemAlignErr,
  output logic        DataMemWE,
  output logic [31:0] DataMemAddr,
  output logic [31:0] DataMemIn,
  input  logic [31:0] DataMemOut
);
  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, DONE} state_t;
  state_t state, state_nx;
  logic wr_q, sgn_q, err_q, mis, accept, sub_st;
  logic [1:0] size_q, off_q;
  logic [7:0] byte_v;
  logic [15:0] half_v;
  logic [31:0] load_v, merged;
  assign mis = (MemSize == 2'b01 && MemAddr[0]) || (MemSize == 2'b10 && MemAddr[1:0] != 2'b00) || MemSize == 2'b11;
  assign accept = state == IDLE && MemReq;
  assign sub_st = wr_q && size_q != 2'b10;
  // DataMemIn holds the right-aligned store data from accept until ACCESS, so it doubles as the merge source
  always_comb begin
    byte_v = DataMemOut[{off_q, 3'b000} +: 8];
    half_v = off_q[1] ? DataMemOut[31:16] : DataMemOut[15:0];
    load_v = size_q == 2'b00 ? {{24{sgn_q & byte_v[7]}}, byte_v} :
             size_q == 2'b01 ? {{16{sgn_q & half_v[15]}}, half_v} : DataMemOut;
    merged = DataMemOut;
    if (size_q == 2'b00) merged[{off_q, 3'b000} +: 8] = DataMemIn[7:0];
    else merged[{off_q[1], 4'b0000} +: 16] = DataMemIn[15:0];
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = MemReq ? (mis ? DONE : ACCESS) : IDLE;
      ACCESS:  state_nx = sub_st ? WRITE : DONE;
      WRITE:   state_nx = DONE;
      default: state_nx = IDLE;
    endcase
    MemDone = state == DONE;
    MemAlignErr = state == DONE && err_q;
    MemStall = accept || state == ACCESS || state == WRITE;
    DataMemWE = (state == ACCESS && wr_q && size_q == 2'b10) || state == WRITE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      wr_q <= 1'b0;
      sgn_q <= 1'b0;
      err_q <= 1'b0;
      size_q <= 2'b00;
      off_q <= 2'b00;
      MemRData <= 32'h0;
      DataMemAddr <= 32'h0;
      DataMemIn <= 32'h0;
    end else begin
      state <= state_nx;
      if (accept) begin
        wr_q <= MemWrite;
        size_q <= MemSize;
        sgn_q <= MemSigned;
        off_q <= MemAddr[1:0];
        err_q <= mis;
        DataMemAddr <= {MemAddr[31:2], 2'b00};
        DataMemIn <= MemWData;
        if (mis) MemRData <= 32'h0;
      end
      if (state == ACCESS && !wr_q) MemRData <= load_v;
      if (state == ACCESS && sub_st) DataMemIn <= merged;
    end
  end
endmodule
